// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction-line fetch sequencer between the IF stage and the instruction
//   memory bus. A one-line (two-instruction) buffer serves IF addresses in the
//   current 8-byte line with zero latency. A miss issues one req/gnt/rvalid
//   transaction and stalls IF until the line returns. A response timeout parks
//   the block in a sticky error state that only reset clears.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous reset, active low
//   if_addr     IF fetch address (PC); line tag = if_addr[ADDR_W-1:3]
//   if_inst     line for IF: [63:32] = instr at line+0, [31:0] = instr at line+4
//   if_stall    1 = if_inst is not valid for if_addr
//   inv         invalidate the fetch buffer
//   mem_req     bus request (registered)
//   mem_addr    bus line address {tag,3'b000} (registered, frozen while mem_req)
//   mem_gnt     bus accepts the request this cycle
//   mem_rvalid  read data valid
//   mem_rdata   read data
//   fetch_err   sticky response-timeout error
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int unsigned      ADDR_W   = 32,
   parameter int unsigned      DATA_W   = 64,
   parameter int unsigned      TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] NOP_LINE = 64'h0000_0013_0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_inst,
   output logic              if_stall,
   input  logic              inv,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fetch_err
);

   localparam int unsigned TAG_W = ADDR_W - 3;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DROP,
      ERR
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               buf_vld;
   logic [TAG_W-1:0]   buf_tag;
   logic [DATA_W-1:0]  buf_data;
   logic [TAG_W-1:0]   req_tag;
   logic [7:0]         tmo_cnt;
   logic               inv_pend;   // inv seen while the request is still ungranted

   logic [TAG_W-1:0]   if_tag;
   logic               hit;
   logic               tmo_last;
   logic               fill;

   assign if_tag   = if_addr[ADDR_W-1:3];
   assign hit      = buf_vld && (buf_tag == if_tag) && (state != ERR);
   assign if_stall = ~hit;
   assign if_inst  = hit ? buf_data : NOP_LINE;

   // Compared before the increment, so ERR follows exactly TIMEOUT silent
   // WAIT/DROP cycles counted from the grant.
   assign tmo_last = (tmo_cnt == 8'(TIMEOUT - 1));

   // inv in the same cycle as the response wins: the line is dropped.
   assign fill     = (state == WAIT) && mem_rvalid && !inv;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned; without it synthesis would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (!hit && !inv) state_nxt = REQ;
         REQ:  if (mem_gnt) state_nxt = (inv || inv_pend) ? DROP : WAIT;
         WAIT: begin
            if (inv)             state_nxt = mem_rvalid ? IDLE : DROP;
            else if (mem_rvalid) state_nxt = IDLE;
            else if (tmo_last)   state_nxt = ERR;
         end
         DROP: begin
            if (mem_rvalid)      state_nxt = IDLE;
            else if (tmo_last)   state_nxt = ERR;
         end
         ERR:  state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld   <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
         req_tag   <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         tmo_cnt   <= '0;
         inv_pend  <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         // Buffer: inv clears validity in any state and overrides a fill.
         if (inv) begin
            buf_vld <= 1'b0;
         end else if (fill) begin
            buf_vld <= 1'b1;
         end
         if (fill) begin
            buf_tag  <= req_tag;
            buf_data <= mem_rdata;
         end

         // Request is held high for the whole REQ state, so it can only rise
         // on the IDLE->REQ edge and never in WAIT/DROP.
         mem_req <= (state_nxt == REQ);
         if (state == IDLE && state_nxt == REQ) begin
            req_tag  <= if_tag;
            mem_addr <= {if_tag, 3'b000};
         end

         if (state == REQ) inv_pend <= mem_gnt ? 1'b0 : (inv_pend || inv);
         else              inv_pend <= 1'b0;

         if (state == REQ && mem_gnt) begin
            tmo_cnt <= '0;
         end else if ((state == WAIT || state == DROP) && !mem_rvalid) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end

         if (state_nxt == ERR) fetch_err <= 1'b1;
      end
   end

endmodule
